// File: rtl/flash_port_arbiter_if.sv
// Signal bundle between the two flash masters, the arbiter and the flash pads.
//
// Handshake: a master raises reqX and holds it high for its whole flash
// transaction. The arbiter answers with a registered gntX; while gntX is high
// the master's fsclkX/fcenX/fdoX/fdoeX drive the pads and fdiX returns the pad
// data. The master ends the transaction by dropping reqX with fcenX high on
// the same cycle; gntX falls after that edge and the pads go idle.
interface flash_port_arbiter_if;
    // Requester handshake
    logic       req0;
    logic       req1;
    logic       gnt0;
    logic       gnt1;

    // Master-side pin requests
    logic       fsclk0;
    logic       fcen0;
    logic       fdoe0;
    logic [3:0] fdo0;
    logic       fsclk1;
    logic       fcen1;
    logic       fdoe1;
    logic [3:0] fdo1;

    // Pad data returned to each master
    logic [3:0] fdi0;
    logic [3:0] fdi1;

    // Pad side
    logic       fsclk;
    logic       fcen;
    logic       fdoe;
    logic [3:0] fdo;
    logic [3:0] fdi;

    // Current owner: 2'b00 none, 2'b01 master 0, 2'b10 master 1
    logic [1:0] owner;

    // Arbiter view
    modport slave (
        input  req0, req1,
        input  fsclk0, fcen0, fdoe0, fdo0,
        input  fsclk1, fcen1, fdoe1, fdo1,
        input  fdi,
        output gnt0, gnt1,
        output fdi0, fdi1,
        output fsclk, fcen, fdoe, fdo,
        output owner
    );

    // Masters plus pads view
    modport master (
        output req0, req1,
        output fsclk0, fcen0, fdoe0, fdo0,
        output fsclk1, fcen1, fdoe1, fdo1,
        output fdi,
        input  gnt0, gnt1,
        input  fdi0, fdi1,
        input  fsclk, fcen, fdoe, fdo,
        input  owner
    );
endinterface

// File: rtl/flash_port_arbiter.sv
// Two-master arbiter for the quad-SPI flash pad group. Whole transactions are
// granted, ownership only moves while chip-select is high, and a fixed
// turnaround of TURN_CYCLES idle cycles separates consecutive owners. Ties
// alternate between the masters; master 0 wins the first tie after reset.
module flash_port_arbiter #(
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    flash_port_arbiter_if.slave  bus,
    output logic [1:0]           dbg_state
);

    // Encodings of OWN0/OWN1 match the owner output encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10,
        ST_TURN = 2'b11
    } state_t;

    // Turnaround counter load value: cnt==0 marks the last idle cycle.
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       last_q;
    logic       last_d;

    logic       gnt0_q;
    logic       gnt1_q;
    logic [1:0] owner_q;

    logic       any_req;
    logic       pick1;
    state_t     win_state;

    // Arbitration decision shared by IDLE and the end of TURN: a tie goes to
    // the master that did not own last, otherwise the lone requester wins.
    always_comb begin
        any_req   = bus.req0 | bus.req1;
        pick1     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
        win_state = ST_IDLE;
        if (any_req) begin
            win_state = pick1 ? ST_OWN1 : ST_OWN0;
        end
    end

    // Next-state logic. Release needs reqX low and fcenX high on the same
    // edge, so a master that drops req mid-command keeps the pads until its
    // chip-select is deasserted. The other request never preempts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                state_d = win_state;
            end
            ST_OWN0: begin
                if (!bus.req0 && bus.fcen0) begin
                    state_d = ST_TURN;
                    cnt_d   = TURN_LOAD;
                    last_d  = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!bus.req1 && bus.fcen1) begin
                    state_d = ST_TURN;
                    cnt_d   = TURN_LOAD;
                    last_d  = 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = win_state;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, turnaround counter and last-owner registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Grant and owner flops, loaded from the next state so they track state_q.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            owner_q <= 2'b00;
        end else begin
            gnt0_q  <= (state_d == ST_OWN0);
            gnt1_q  <= (state_d == ST_OWN1);
            owner_q <= (state_d == ST_OWN0) ? 2'b01 :
                       (state_d == ST_OWN1) ? 2'b10 : 2'b00;
        end
    end

    // Pad mux selected by the registered state only; idle pattern keeps the
    // flash deselected with outputs disabled whenever nobody owns the pads.
    always_comb begin
        bus.fsclk = 1'b0;
        bus.fcen  = 1'b1;
        bus.fdoe  = 1'b0;
        bus.fdo   = 4'h0;
        bus.fdi0  = 4'h0;
        bus.fdi1  = 4'h0;
        case (state_q)
            ST_OWN0: begin
                bus.fsclk = bus.fsclk0;
                bus.fcen  = bus.fcen0;
                bus.fdoe  = bus.fdoe0;
                bus.fdo   = bus.fdo0;
                bus.fdi0  = bus.fdi;
            end
            ST_OWN1: begin
                bus.fsclk = bus.fsclk1;
                bus.fcen  = bus.fcen1;
                bus.fdoe  = bus.fdoe1;
                bus.fdo   = bus.fdo1;
                bus.fdi1  = bus.fdi;
            end
            default: begin
                bus.fsclk = 1'b0;
                bus.fcen  = 1'b1;
            end
        endcase
    end

    // Registered handshake outputs and state visibility.
    always_comb begin
        bus.gnt0  = gnt0_q;
        bus.gnt1  = gnt1_q;
        bus.owner = owner_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Bench for flash_port_arbiter: a directed vector table, hand sequences for
// async reset, single request and chip-select hold, randomized traffic against
// a timestamp-based reference model, and two extra instances with
// TURN_CYCLES=1 and 15 running alternating masters to measure idle gaps.
module tb_flash_port_arbiter;

    localparam int TURN = 2;

    logic HCLK;
    logic HRESETn;
    logic rst_c;
    logic [1:0] dbg_state;

    int n_chk;
    int n_fail;

    flash_port_arbiter_if bus();

    flash_port_arbiter #(.TURN_CYCLES(TURN)) u_dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- comparison helper ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Ownership plus a timestamp of the earliest edge at which the pads may
    // be handed out again.
    logic [1:0] m_owner;
    int         m_last;
    int         m_cyc;
    int         m_free;
    logic [1:0] exp_q[$];
    logic [1:0] dut_prev_owner;

    task automatic m_reset();
        m_owner        = 2'b00;
        m_last         = 1;
        m_cyc          = 0;
        m_free         = 0;
        dut_prev_owner = 2'b00;
        exp_q.delete();
    endtask

    task automatic model_edge();
        m_cyc++;
        if (m_owner == 2'b01) begin
            if (!bus.req0 && bus.fcen0) begin
                m_owner = 2'b00; m_last = 0; m_free = m_cyc + TURN;
            end
        end else if (m_owner == 2'b10) begin
            if (!bus.req1 && bus.fcen1) begin
                m_owner = 2'b00; m_last = 1; m_free = m_cyc + TURN;
            end
        end else if (m_cyc >= m_free) begin
            if (bus.req0 && bus.req1) m_owner = (m_last == 1) ? 2'b01 : 2'b10;
            else if (bus.req0)        m_owner = 2'b01;
            else if (bus.req1)        m_owner = 2'b10;
            if (m_owner != 2'b00) exp_q.push_back(m_owner);
        end
    endtask

    task automatic check_all();
        logic       e_sclk, e_cen, e_oe;
        logic [3:0] e_do, e_di0, e_di1;
        logic [1:0] got;
        e_sclk = 1'b0; e_cen = 1'b1; e_oe = 1'b0; e_do = 4'h0; e_di0 = 4'h0; e_di1 = 4'h0;
        if (m_owner == 2'b01) begin
            e_sclk = bus.fsclk0; e_cen = bus.fcen0; e_oe = bus.fdoe0; e_do = bus.fdo0; e_di0 = bus.fdi;
        end else if (m_owner == 2'b10) begin
            e_sclk = bus.fsclk1; e_cen = bus.fcen1; e_oe = bus.fdoe1; e_do = bus.fdo1; e_di1 = bus.fdi;
        end
        chk("gnt0",  bus.gnt0,  m_owner == 2'b01);
        chk("gnt1",  bus.gnt1,  m_owner == 2'b10);
        chk("owner", bus.owner, m_owner);
        chk("fsclk", bus.fsclk, e_sclk);
        chk("fcen",  bus.fcen,  e_cen);
        chk("fdoe",  bus.fdoe,  e_oe);
        chk("fdo",   bus.fdo,   e_do);
        chk("fdi0",  bus.fdi0,  e_di0);
        chk("fdi1",  bus.fdi1,  e_di1);
        if (dut_prev_owner == 2'b00 && bus.owner != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("grant_unexpected", bus.owner, 2'b00);
            end else begin
                got = exp_q.pop_front();
                chk("grant_order", bus.owner, got);
            end
        end
        dut_prev_owner = bus.owner;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge HCLK);
        model_edge();
        @(negedge HCLK);
        check_all();
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.fsclk0 = 1'b0; bus.fcen0 = 1'b1; bus.fdoe0 = 1'b0; bus.fdo0 = 4'h0;
        bus.fsclk1 = 1'b0; bus.fcen1 = 1'b1; bus.fdoe1 = 1'b0; bus.fdo1 = 4'h0;
        bus.fdi = 4'h5;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        idle_inputs();
        HRESETn = 1'b0;
        m_reset();
        @(negedge HCLK);
        chk("rst_gnt0",  bus.gnt0,  1'b0);
        chk("rst_gnt1",  bus.gnt1,  1'b0);
        chk("rst_owner", bus.owner, 2'b00);
        chk("rst_fcen",  bus.fcen,  1'b1);
        chk("rst_fdoe",  bus.fdoe,  1'b0);
        chk("rst_fdi0",  bus.fdi0,  4'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       req0;
        logic       req1;
        logic       fcen0;
        logic       fcen1;
        logic       gnt0;
        logic       gnt1;
        logic [1:0] owner;
        logic       pad_fcen;
    } vec_t;

    vec_t vecs[18];

    // ---------------- parameter corner instances ----------------
    for (genvar g = 0; g < 2; g++) begin : g_corner
        localparam int TC = (g == 0) ? 1 : 15;
        flash_port_arbiter_if cif();
        logic [1:0] cdbg;
        int gap_log[16];
        logic [1:0] own_log[16];
        int n_gap;
        int n_own;
        int bad_idle;

        flash_port_arbiter #(.TURN_CYCLES(TC)) u_c (
            .HCLK      (HCLK),
            .HRESETn   (rst_c),
            .bus       (cif),
            .dbg_state (cdbg)
        );

        // Both masters request continuously, hold chip-select for 3 cycles
        // once granted, release, and immediately request again.
        initial begin
            int h0, h1;
            h0 = 0; h1 = 0;
            cif.req0 = 1'b1; cif.req1 = 1'b1;
            cif.fcen0 = 1'b1; cif.fcen1 = 1'b1;
            cif.fsclk0 = 1'b1; cif.fsclk1 = 1'b1;
            cif.fdoe0 = 1'b1; cif.fdoe1 = 1'b1;
            cif.fdo0 = 4'h3; cif.fdo1 = 4'hC; cif.fdi = 4'h9;
            forever begin
                @(negedge HCLK);
                if (cif.gnt0) begin
                    if (h0 < 3) begin cif.fcen0 = 1'b0; h0++; end
                    else begin cif.req0 = 1'b0; cif.fcen0 = 1'b1; end
                end else begin
                    cif.req0 = 1'b1; cif.fcen0 = 1'b1; h0 = 0;
                end
                if (cif.gnt1) begin
                    if (h1 < 3) begin cif.fcen1 = 1'b0; h1++; end
                    else begin cif.req1 = 1'b0; cif.fcen1 = 1'b1; end
                end else begin
                    cif.req1 = 1'b1; cif.fcen1 = 1'b1; h1 = 0;
                end
            end
        end

        // Gap and grant-sequence recorder.
        initial begin
            int idle_run;
            bit started;
            logic [1:0] prev;
            idle_run = 0; started = 0; prev = 2'b00;
            n_gap = 0; n_own = 0; bad_idle = 0;
            forever begin
                @(negedge HCLK);
                if (rst_c) begin
                    if (cif.owner == 2'b00) begin
                        if (started) idle_run++;
                        if (cif.fcen !== 1'b1 || cif.fdoe !== 1'b0 || cif.fsclk !== 1'b0 || cif.fdo !== 4'h0)
                            bad_idle++;
                    end else if (cif.owner != prev) begin
                        if (started && n_gap < 16) begin gap_log[n_gap] = idle_run; n_gap++; end
                        if (n_own < 16) begin own_log[n_own] = cif.owner; n_own++; end
                        started = 1; idle_run = 0;
                    end
                    prev = cif.owner;
                end
            end
        end
    end

    initial begin
        rst_c = 1'b0;
        repeat (3) @(negedge HCLK);
        rst_c = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        n_chk = 0;
        n_fail = 0;
        HRESETn = 1'b0;
        idle_inputs();
        m_reset();

        //            r0 r1 c0 c1 g0 g1 owner  pfcen
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,2'b01,1'b1}; // tie -> master 0
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b01,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'b01,1'b0}; // req low, cs low: hold
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1}; // release
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'b10,1'b1}; // grant 2 after release
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,2'b10,1'b0}; // no preemption
        vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1}; // dropped in TURN
        vecs[10] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'b10,1'b1}; // lone requester
        vecs[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1}; // same master waits
        vecs[14] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'b10,1'b1};
        vecs[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1};
        vecs[16] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1};
        vecs[17] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,2'b01,1'b1}; // tie -> master 0

        // Vector table
        do_reset();
        for (int i = 0; i < 18; i++) begin
            bus.req0 = vecs[i].req0; bus.req1 = vecs[i].req1;
            bus.fcen0 = vecs[i].fcen0; bus.fcen1 = vecs[i].fcen1;
            tick();
            chk($sformatf("vec%0d_gnt0", i),  bus.gnt0,  vecs[i].gnt0);
            chk($sformatf("vec%0d_gnt1", i),  bus.gnt1,  vecs[i].gnt1);
            chk($sformatf("vec%0d_owner", i), bus.owner, vecs[i].owner);
            chk($sformatf("vec%0d_fcen", i),  bus.fcen,  vecs[i].pad_fcen);
        end

        // Single request at edge 5 with pin pass-through
        do_reset();
        repeat (4) tick();
        bus.req0 = 1'b1;
        tick();
        chk("single_gnt0",  bus.gnt0,  1'b1);
        chk("single_owner", bus.owner, 2'b01);
        bus.fsclk0 = 1'b1; #1;
        chk("single_fsclk_hi", bus.fsclk, 1'b1);
        bus.fsclk0 = 1'b0; #1;
        chk("single_fsclk_lo", bus.fsclk, 1'b0);
        bus.fdi = 4'hA; #1;
        chk("single_fdi0", bus.fdi0, 4'hA);
        chk("single_fdi1", bus.fdi1, 4'h0);

        // Chip-select held low after req drops: 3 cycles of continued ownership
        bus.fcen0 = 1'b0;
        tick();
        bus.req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_gnt0",  bus.gnt0,  1'b1);
            chk("hold_owner", bus.owner, 2'b01);
        end
        bus.fcen0 = 1'b1;
        tick();
        chk("hold_release_gnt0", bus.gnt0, 1'b0);
        chk("hold_release_fcen", bus.fcen, 1'b1);

        // Asynchronous reset while master 1 drives the pads
        do_reset();
        bus.req1 = 1'b1;
        tick();
        bus.fcen1 = 1'b0; bus.fdoe1 = 1'b1;
        tick();
        chk("pre_rst_fdoe", bus.fdoe, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_fcen",  bus.fcen,  1'b1);
        chk("arst_fdoe",  bus.fdoe,  1'b0);
        chk("arst_gnt1",  bus.gnt1,  1'b0);
        chk("arst_owner", bus.owner, 2'b00);
        // After reset a tie must go to master 0 again
        @(negedge HCLK);
        m_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.fcen1 = 1'b1; bus.fdoe1 = 1'b0;
        HRESETn = 1'b1;
        tick();
        chk("arst_tie_owner", bus.owner, 2'b01);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 5) == 0) bus.req1 = ~bus.req1;
            bus.fcen0  = ($urandom_range(0, 2) != 0);
            bus.fcen1  = ($urandom_range(0, 2) != 0);
            bus.fsclk0 = 1'($urandom_range(0, 1));
            bus.fsclk1 = 1'($urandom_range(0, 1));
            bus.fdoe0  = 1'($urandom_range(0, 1));
            bus.fdoe1  = 1'($urandom_range(0, 1));
            bus.fdo0   = 4'($urandom_range(0, 15));
            bus.fdo1   = 4'($urandom_range(0, 15));
            bus.fdi    = 4'($urandom_range(0, 15));
            tick();
        end
        chk("exp_q_empty", exp_q.size(), 0);

        // Parameter corners: wait (bounded) for enough grants, then check
        for (int i = 0; i < 3000 && (g_corner[0].n_own < 12 || g_corner[1].n_own < 12); i++)
            @(negedge HCLK);
        chk("c1_count",  g_corner[0].n_own >= 12, 1'b1);
        chk("c15_count", g_corner[1].n_own >= 12, 1'b1);
        chk("c1_bad_idle",  g_corner[0].bad_idle, 0);
        chk("c15_bad_idle", g_corner[1].bad_idle, 0);
        for (int i = 0; i < 10; i++) begin
            if (i < g_corner[0].n_gap) chk($sformatf("c1_gap%0d", i), g_corner[0].gap_log[i], 1);
            if (i < g_corner[1].n_gap) chk($sformatf("c15_gap%0d", i), g_corner[1].gap_log[i], 15);
            if (i < g_corner[0].n_own)
                chk($sformatf("c1_own%0d", i), g_corner[0].own_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i < g_corner[1].n_own)
                chk($sformatf("c15_own%0d", i), g_corner[1].own_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_port_arbiter.md
# flash_port_arbiter

Arbitrates the single external quad-SPI flash pad group (fdi/fdo/fdoe/fsclk/fcen) between two on-chip masters: requester 0, the SoC core flash controller, and requester 1, a host-side flash programmer. Whole transactions are granted per requester, and ownership never changes while chip-select is active. A fixed chip-select-high turnaround is enforced between owners. The block sits between the masters and the user IO pads; it drives the pads to a safe idle pattern whenever nobody owns them.

## Interface
- TURN_CYCLES, default 2: number of cycles the pads are held idle between one owner's release and the next grant. Legal range 1..15.
- HCLK  in  1  sole clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from master 0 / 1. Held high for the whole transaction.
- gnt0 / gnt1  out  1  grant to master 0 / 1. Registered and mutually exclusive.
- fsclk0, fcen0, fdoe0 / fsclk1, fcen1, fdoe1  in  1 each  master-side pin requests. fcenX is active-low chip-select; fdoeX is the active-high data output enable.
- fdo0 / fdo1  in  4  master-side output data.
- fdi0 / fdi1  out  4  pad input data returned to a master. Equals fdi while that master owns the pads, else 4'h0.
- fsclk, fcen, fdoe  out  1 each  pad-side clock, chip-select and output enable.
- fdo  out  4  pad-side output data.
- fdi  in  4  pad-side input data.
- owner  out  2  2'b00 none, 2'b01 master 0, 2'b10 master 1.

## Operation
- States: IDLE, OWN0, OWN1, TURN. A 4-bit down-counter `cnt` runs in TURN. A `last` bit records the most recent owner and resets to 1, so master 0 wins the first tie.
- Pad mux is decoded from the registered state only; there is no combinational path from req to pads.
  - OWNx: pads = master x's fsclk/fcen/fdo/fdoe; fdiX = fdi; the other master's fdi output = 0.
  - IDLE/TURN: fsclk=0, fcen=1, fdo=4'h0, fdoe=0, fdi0=fdi1=0.
- IDLE, per edge:
  - req0 & req1 → OWN(~last).
  - Otherwise, the single requester → OWN of that requester.
  - No request → stay in IDLE.
- OWNx: gntX=1. The release condition is reqX==0 **and** fcenX==1, sampled on the same edge.
  - On release: → TURN, cnt=TURN_CYCLES-1, last=x, gntX cleared on that edge.
  - reqX low while fcenX is still low: hold ownership until fcenX goes high. This is a protocol violation that the arbiter tolerates.
  - The other master's request never preempts the current owner.
- TURN: cnt decrements each edge. On the edge where cnt==0, arbitrate exactly as in IDLE; if no request, → IDLE.
- gnt0 = (state==OWN0), gnt1 = (state==OWN1), owner decoded likewise. All are registered outputs.

## Timing
- Reset (asynchronous, immediate, no clock needed): state=IDLE, last=1, cnt=0, gnt0=gnt1=0, owner=0, fsclk=0, fcen=1, fdo=0, fdoe=0, fdi0=fdi1=0.
- Request-to-grant from IDLE: req sampled high at edge N → gnt high after edge N, i.e. 1 cycle.
- Pad switch is coincident with the grant. The first master pin value reaches the pads in the same cycle gnt is first seen high.
- Release: edge R samples req low and fcen high → after R, gnt=0 and pads idle.
  - Pads stay idle for exactly TURN_CYCLES cycles.
  - The next grant is visible TURN_CYCLES cycles after R, when a request is pending.
- Back-to-back same master: after a release, a master that re-requests still waits the full turnaround, and wins if it is the only requester.
- Simultaneous requests: alternate strictly, with no starvation. Worst-case wait is one transaction plus TURN_CYCLES.
- A request dropped during TURN is not granted. A request raised during TURN is considered at the cnt==0 edge.
- Reset mid-transaction: pads go idle asynchronously (fcen=1, fdoe=0), aborting the flash command. Arbitration restarts with master 0 preferred.

## Test plan
- Reset: assert HRESETn=0 mid-OWN1 with fdoe1=1, fcen1=0 → immediately fcen=1, fdoe=0, gnt1=0, owner=0, with no clock edge required.
- Single request: req0 rises at edge 5 → gnt0=1 and owner=01 after edge 5; fsclk toggles pass through to fsclk; fdi=4'hA gives fdi0=4'hA and fdi1=4'h0.
- Tie and round-robin: req0 and req1 rise together from reset → master 0 is granted first. Master 0 releases; with TURN_CYCLES=2, gnt1 rises 2 cycles after the release edge; fcen stays 1 in between.
- No preemption: master 1 owns with fcen1=0, req0 rises → gnt0 stays 0 until master 1 drops req1 with fcen1=1.
- Protocol violation: master 0 drops req0 while fcen0=0 for 3 cycles → gnt0 stays 1 and owner stays 01 until fcen0=1; TURN is entered on that edge.
- Parameter corner: TURN_CYCLES=1 and TURN_CYCLES=15, with continuous alternating requests → measured idle gap is exactly 1 and 15 cycles, and grants alternate 0,1,0,1.
